// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480 VGA timing constants, grid geometry, cell codes and colour decode
package vga_pkg;

  localparam int H_TOTAL  = 800;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_ACTIVE = 640;
  localparam int V_TOTAL  = 521;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 29;
  localparam int V_ACTIVE = 480;

  localparam int H_VIS_START = H_SYNC + H_BP;
  localparam int V_VIS_START = V_SYNC + V_BP;

  localparam int GRID_DIM = 7;
  localparam int GRID_W   = GRID_DIM * GRID_DIM * 2;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    ACQUIRE,
    ARMED,
    CAPTURE
  } cap_state_t;

  // Pure red marks player 1, pure yellow player 2; any other colour is empty.
  function automatic cell_t decode_cell(input logic [2:0] r, input logic [2:0] g,
                                        input logic [1:0] b);
    cell_t code;
    code = EMPTY;
    if (r == 3'd7 && b == 2'd0 && g == 3'd0) code = P1;
    else if (r == 3'd7 && b == 2'd0 && g == 3'd7) code = P2;
    return code;
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// rtl/vga_sync_counter.sv - sync edge detection and h/v position counters; VGA_CAP_CHECK_EN adds timing checks
module vga_sync_counter
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] h_nxt,
  output logic [9:0] v_nxt,
  output logic       v_fall,
  output logic       timing_err
);

  logic       hs_q;
  logic       vs_q;
  logic       h_fall;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;

  assign h_fall = pix_en & hs_q & ~hsync;
  assign v_fall = pix_en & vs_q & ~vsync;

  // h_nxt/v_nxt are the coordinates of the pixel presented on this strobe.
  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (pix_en) begin
      if (h_fall) h_nxt = '0;
      else if (h_cnt != 10'(H_TOTAL - 1)) h_nxt = h_cnt + 10'd1;
      if (v_fall) v_nxt = '0;
      else if (h_fall && v_cnt != 10'(V_TOTAL - 1)) v_nxt = v_cnt + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else if (pix_en) begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      hs_q  <= hsync;
      vs_q  <= vsync;
    end
  end

`ifdef VGA_CAP_CHECK_EN
  assign timing_err = (h_fall && h_cnt != 10'(H_TOTAL - 1)) ||
                      (v_fall && v_cnt != 10'(V_TOTAL - 1));
`else
  assign timing_err = 1'b0;
`endif

endmodule

// File: rtl/vga_grid_capture.sv
// rtl/vga_grid_capture.sv - samples a 7x7 cell grid from a VGA stream and commits it once per clean frame
module vga_grid_capture
  import vga_pkg::*;
#(
  parameter int CELL    = 64,
  parameter int GRID_X0 = 96,
  parameter int GRID_Y0 = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  input  logic              Hsync,
  input  logic              Vsync,
  input  logic [2:0]        vgaRed,
  input  logic [2:0]        vgaGreen,
  input  logic [1:0]        vgaBlue,
  output logic [GRID_W-1:0] grid,
  output logic              frame_valid,
  output logic              sync_err
);

  logic [9:0]          h_nxt;
  logic [9:0]          v_nxt;
  logic                v_fall;
  logic                timing_err;
  logic                err_now;
  logic                frame_err;
  logic                bad;
  logic                commit;
  logic [GRID_DIM-1:0] col_hit;
  logic [GRID_DIM-1:0] row_hit;
  logic [GRID_W-1:0]   shadow;
  cap_state_t          state;
  cap_state_t          state_nxt;

  vga_sync_counter u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_en     (pix_en),
    .hsync      (Hsync),
    .vsync      (Vsync),
    .h_nxt      (h_nxt),
    .v_nxt      (v_nxt),
    .v_fall     (v_fall),
    .timing_err (timing_err)
  );

  for (genvar k = 0; k < GRID_DIM; k++) begin : g_hit
    localparam int XS = GRID_X0 + k * CELL + CELL / 2;
    localparam int YS = GRID_Y0 + k * CELL + CELL / 2;
    assign col_hit[k] = (XS < H_ACTIVE) && (h_nxt == 10'(H_VIS_START + XS));
    assign row_hit[k] = (YS < V_ACTIVE) && (v_nxt == 10'(V_VIS_START + YS));
  end

  // Counters are meaningless until the first Vsync fall, so errors only count afterwards.
  assign err_now = timing_err & (state != ACQUIRE);
  assign bad     = frame_err | err_now;
  assign commit  = v_fall & (state == CAPTURE) & ~bad;

  always_comb begin
    state_nxt = state;
    case (state)
      ACQUIRE: if (v_fall) state_nxt = ARMED;
      ARMED:   if (v_fall) state_nxt = CAPTURE;
      CAPTURE: if (v_fall && bad) state_nxt = ARMED;
      default: state_nxt = ACQUIRE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACQUIRE;
      grid        <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      frame_valid <= commit;
      if (commit) grid <= shadow;
      if (v_fall) frame_err <= 1'b0;
      else if (err_now) frame_err <= 1'b1;
      if (err_now) sync_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (pix_en) begin
      for (int r = 0; r < GRID_DIM; r++) begin
        for (int c = 0; c < GRID_DIM; c++) begin
          if (row_hit[r] && col_hit[c])
            shadow[2*(r*GRID_DIM+c) +: 2] <= decode_cell(vgaRed, vgaGreen, vgaBlue);
        end
      end
    end
  end

endmodule
